con_mdr_pcinc_unit: RTL and testbench

//  Datapath support block for the 32-bit bus CPU with three independent sub-functions:
//   - CON flip-flop: evaluates the branch condition for conditional branches.
//   - Memory data register (MDR): holds data read from RAM or driven from the bus.
//   - PC incrementer: produces the next-PC value that the PC register loads.

---
 rtl/con_mdr_pcinc_unit.sv | 90 +++++++++
 tb/tb_con_mdr_pcinc_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/con_mdr_pcinc_unit.sv
// con_mdr_pcinc_unit: CON flip-flop, memory data register and PC incrementer.
// These three datapath helpers sit beside the bus mux and work independently.
//
// Ports
//   clk, clr     : system clock; synchronous active-high reset
//   con_in       : load strobe for the branch-condition flop
//   ir           : instruction register; C2 = ir[COND_LSB+1:COND_LSB]
//   bus_in       : bus value; holds R[Ra] while CON is evaluated, and is an MDR source
//   branch_flag  : registered branch-taken flag
//   mdr_in       : MDR load enable
//   mdr_read     : MDR source select (1 = mem_data_in, 0 = bus_in)
//   mem_data_in  : RAM read data
//   mdr_out      : MDR contents
//   inc_pc       : when 1, pc_inc_out = pc_in + PC_STEP
//   pc_in        : current PC value
//   pc_inc_out   : next-PC value (combinational)
module con_mdr_pcinc_unit #(
  parameter int WIDTH    = 32,
  parameter int PC_STEP  = 1,
  parameter int COND_LSB = 19
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             con_in,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] bus_in,
  output logic             branch_flag,
  input  logic             mdr_in,
  input  logic             mdr_read,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] mdr_out,
  input  logic             inc_pc,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_inc_out
);

  typedef enum logic [1:0] {
    C_BRZR = 2'b00,
    C_BRNZ = 2'b01,
    C_BRPL = 2'b10,
    C_BRMI = 2'b11
  } cond_e;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  cond_e c2;
  logic  bus_zero;
  logic  bus_neg;
  logic  cond_taken;

  logic [WIDTH-1:0] mdr_d;

  assign c2       = cond_e'(ir[COND_LSB+1:COND_LSB]);
  assign bus_zero = (bus_in == '0);
  assign bus_neg  = bus_in[WIDTH-1];

  // Zero is treated as positive for brpl.
  always_comb begin
    cond_taken = 1'b0;
    unique case (c2)
      C_BRZR: cond_taken = bus_zero;
      C_BRNZ: cond_taken = !bus_zero;
      C_BRPL: cond_taken = !bus_neg;
      C_BRMI: cond_taken = bus_neg;
      default: cond_taken = 1'b0;
    endcase
  end

  assign mdr_d = mdr_read ? mem_data_in : bus_in;

  always_ff @(posedge clk) begin
    if (clr) begin
      branch_flag <= 1'b0;
    end else if (con_in) begin
      branch_flag <= cond_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mdr_out <= '0;
    end else if (mdr_in) begin
      mdr_out <= mdr_d;
    end
  end

  // Wraps modulo 2^WIDTH; the carry is dropped.
  assign pc_inc_out = inc_pc ? (pc_in + STEP) : pc_in;

endmodule

// File: tb/tb_con_mdr_pcinc_unit.sv
// tb_con_mdr_pcinc_unit: scoreboard bench for con_mdr_pcinc_unit.
// Directed cases followed by random cycles, checked against a behavioural model.
module tb_con_mdr_pcinc_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        con_in = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] bus_in = '0;
  logic        branch_flag;
  logic        mdr_in = 1'b0;
  logic        mdr_read = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic [31:0] mdr_out;
  logic        inc_pc = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] pc_inc_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        bf;
    logic [31:0] mdr;
    logic [31:0] pc;
    bit          regs_ok;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  logic        m_bf = 1'b0;
  logic [31:0] m_mdr = '0;
  bit          m_known = 1'b0;

  always #5 clk = ~clk;

  con_mdr_pcinc_unit dut (
    .clk(clk),
    .clr(clr),
    .con_in(con_in),
    .ir(ir),
    .bus_in(bus_in),
    .branch_flag(branch_flag),
    .mdr_in(mdr_in),
    .mdr_read(mdr_read),
    .mem_data_in(mem_data_in),
    .mdr_out(mdr_out),
    .inc_pc(inc_pc),
    .pc_in(pc_in),
    .pc_inc_out(pc_inc_out)
  );

  function automatic logic taken(input logic [31:0] i, input logic [31:0] b);
    int c;
    int v;
    c = int'(i[20:19]);
    v = int'(b);
    if (c == 0) return b == 32'd0;
    if (c == 1) return b != 32'd0;
    if (c == 2) return v >= 0;
    return v < 0;
  endfunction

  // Apply one cycle of inputs, queue what must be seen at the following
  // negedge, then advance the model across the rising edge.
  task automatic cyc(
    input string       tag,
    input logic        clr_v,
    input logic        con_v,
    input logic [31:0] ir_v,
    input logic [31:0] bus_v,
    input logic        mi_v,
    input logic        rd_v,
    input logic [31:0] mem_v,
    input logic        inc_v,
    input logic [31:0] pc_v
  );
    exp_t e;
    longint unsigned s;
    clr = clr_v;
    con_in = con_v;
    ir = ir_v;
    bus_in = bus_v;
    mdr_in = mi_v;
    mdr_read = rd_v;
    mem_data_in = mem_v;
    inc_pc = inc_v;
    pc_in = pc_v;
    s = longint'(pc_v) + (inc_v ? 64'd1 : 64'd0);
    e.bf = m_bf;
    e.mdr = m_mdr;
    e.pc = s[31:0];
    e.regs_ok = m_known;
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (clr_v) begin
      m_bf = 1'b0;
      m_mdr = '0;
      m_known = 1'b1;
    end else begin
      if (con_v) m_bf = taken(ir_v, bus_v);
      if (mi_v) m_mdr = rd_v ? mem_v : bus_v;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if (pc_inc_out !== e.pc) begin
        bad++;
        $display("FAIL %s pc_inc_out: got %h want %h", e.tag, pc_inc_out, e.pc);
      end
      if (e.regs_ok) begin
        total++;
        if (branch_flag !== e.bf) begin
          bad++;
          $display("FAIL %s branch_flag: got %b want %b", e.tag, branch_flag, e.bf);
        end
        total++;
        if (mdr_out !== e.mdr) begin
          bad++;
          $display("FAIL %s mdr_out: got %h want %h", e.tag, mdr_out, e.mdr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] C00 = 32'h0000_0000;
  localparam logic [31:0] C01 = 32'h0008_0000;
  localparam logic [31:0] C10 = 32'h0010_0000;
  localparam logic [31:0] C11 = 32'h0018_0000;

  initial begin
    logic [31:0] r_ir;
    logic [31:0] r_bus;
    int          sel;
    @(posedge clk);
    #1;
    cyc("rst", 1, 1, C00, 0, 1, 1, 32'hFFFF_FFFF, 0, 0);
    cyc("rst_chk", 0, 0, C00, 0, 0, 0, 0, 0, 0);
    cyc("brzr0", 0, 1, C00, 0, 0, 0, 0, 0, 0);
    cyc("hold", 0, 0, C00, 5, 0, 0, 0, 0, 0);
    cyc("brzr5", 0, 1, C00, 5, 0, 0, 0, 0, 0);
    cyc("brpl_n", 0, 1, C10, 32'h8000_0000, 0, 0, 0, 0, 0);
    cyc("brmi_n", 0, 1, C11, 32'h8000_0000, 0, 0, 0, 0, 0);
    cyc("brpl_0", 0, 1, C10, 0, 0, 0, 0, 0, 0);
    cyc("brmi_0", 0, 1, C11, 0, 0, 0, 0, 0, 0);
    cyc("brnz7", 0, 1, C01, 7, 0, 0, 0, 0, 0);
    cyc("mdr_mem", 0, 0, C00, 0, 1, 1, 32'h1234_5678, 0, 0);
    cyc("mdr_bus", 0, 0, C00, 32'hDEAD_BEEF, 1, 0, 32'h1111_1111, 0, 0);
    cyc("mdr_hold", 0, 0, C00, 32'h0BAD_F00D, 0, 1, 32'h2222_2222, 0, 0);
    cyc("mdr_hold2", 0, 0, C00, 32'h3333_3333, 0, 0, 32'h4444_4444, 0, 0);
    cyc("pc_inc", 0, 0, C00, 0, 0, 0, 0, 1, 32'h10);
    cyc("pc_noinc", 0, 0, C00, 0, 0, 0, 0, 0, 32'h10);
    cyc("pc_wrap", 0, 0, C00, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc("all3", 0, 1, C11, 32'hF000_0001, 1, 0, 0, 1, 32'h7FFF_FFFF);
    cyc("all3b", 0, 1, C00, 32'h0000_0001, 1, 1, 32'hCAFE_0000, 1, 32'h20);
    cyc("rst_mid", 1, 1, C00, 0, 1, 1, 32'h5555_5555, 1, 32'h30);
    cyc("post_rst", 0, 0, C00, 0, 0, 0, 0, 1, 32'h31);
    for (int n = 0; n < 400; n++) begin
      r_ir = $urandom;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) r_bus = 32'h0;
      else if (sel == 1) r_bus = 32'h8000_0000 | $urandom;
      else r_bus = $urandom;
      cyc("rand",
          ($urandom_range(0, 19) == 0),
          1'($urandom),
          r_ir,
          r_bus,
          1'($urandom),
          1'($urandom),
          $urandom,
          1'($urandom),
          ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
    end
    cyc("tail", 0, 0, C00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
